// File: rtl/bit_serializer_if.sv
// -----------------------------------------------------------------------------
// bit_serializer_if
// Handshake bundle between an upstream word source, the bit serializer and a
// downstream bit consumer.
//   load_valid / data_in / load_ready : parallel word load handshake
//   ser_ready                         : downstream consumes ser_out this cycle
//   ser_out / ser_valid               : serial bit stream, MSB first
//   ser_first / ser_last              : word boundary markers on ser_out
//   word_count                        : words fully shifted out, modulo 256
// Modports: master = upstream/downstream environment, slave = serializer.
// -----------------------------------------------------------------------------
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] data_in;
    logic             load_ready;
    logic             ser_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_first;
    logic             ser_last;
    logic [7:0]       word_count;

    modport master (
        output load_valid, data_in, ser_ready,
        input  load_ready, ser_out, ser_valid, ser_first, ser_last, word_count
    );

    modport slave (
        input  load_valid, data_in, ser_ready,
        output load_ready, ser_out, ser_valid, ser_first, ser_last, word_count
    );
endinterface

// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
// Accepts a WIDTH-bit parallel word and streams it out MSB first, one bit per
// consumed cycle (ser_valid & ser_ready), flagging the first and last bit.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : bit_serializer_if.slave (load handshake, serial stream, word_count)
// Optional feature (macro BIT_SERIALIZER_AUTOLOAD_EN):
//   while the last bit is being consumed a new word may be loaded in the same
//   cycle, so consecutive words stream without a bubble. Without the macro a
//   word is only accepted in IDLE, leaving one idle cycle between words.
// -----------------------------------------------------------------------------
module bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    bit_serializer_if.slave     bus
);
    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;   // held word, current bit always at MSB
    logic [IW-1:0]    idx_q,   idx_d;     // bits already consumed from this word
    logic [7:0]       wcnt_q,  wcnt_d;
    logic             load_ready;
    logic             is_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign is_last = (state_q == SHIFT) && (idx_q == LAST_IDX);

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        idx_d      = idx_q;
        wcnt_d     = wcnt_q;
        load_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                load_ready = 1'b1;
                if (bus.load_valid) begin
                    shreg_d = bus.data_in;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.ser_ready) begin
                    if (is_last) begin
                        wcnt_d  = wcnt_q + 8'd1;
                        state_d = IDLE;
`ifdef BIT_SERIALIZER_AUTOLOAD_EN
                        // Reload in the same edge the LSB leaves: no bubble.
                        load_ready = 1'b1;
                        if (bus.load_valid) begin
                            shreg_d = bus.data_in;
                            idx_d   = '0;
                            state_d = SHIFT;
                        end
`endif
                    end else begin
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are pure decodes of registered state, so reset clears them
    // immediately without waiting for a clock edge.
    assign bus.load_ready = load_ready;
    assign bus.ser_valid  = (state_q == SHIFT);
    assign bus.ser_out    = (state_q == SHIFT) & shreg_q[WIDTH-1];
    assign bus.ser_first  = (state_q == SHIFT) & (idx_q == '0);
    assign bus.ser_last   = is_last;
    assign bus.word_count = wcnt_q;

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
// Scoreboard bench: each accepted word expands into its expected MSB-first
// bit list; a negedge monitor compares the stream, load_ready and word_count.
// -----------------------------------------------------------------------------
module tb_bit_serializer;
    localparam int W = 8;
`ifdef BIT_SERIALIZER_AUTOLOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bit_serializer_if #(.WIDTH(W)) bus ();

    bit_serializer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed { logic b; logic f; logic l; } exp_t;
    exp_t   q[$];
    int     errors = 0;
    int     checks = 0;
    int     model_wc = 0;
    logic   acc_pend = 1'b0;
    logic [W-1:0] acc_data = '0;
    bit     rnd_run = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: a word is W bits, MSB first, first/last flags on ends.
    function automatic void push_word(logic [W-1:0] d);
        for (int i = W - 1; i >= 0; i--)
            q.push_back('{b: d[i], f: (i == W - 1), l: (i == 0)});
    endfunction

    // Record handshakes mid-cycle; the word lands in the scoreboard at the edge.
    always @(negedge clk) begin
        acc_pend <= !rst && bus.load_valid && bus.load_ready;
        acc_data <= bus.data_in;
    end
    always @(posedge clk) if (acc_pend && !rst) push_word(acc_data);

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            chk("ser_valid", 32'(bus.ser_valid), 32'(q.size() != 0));
            chk("word_count", 32'(bus.word_count), 32'(model_wc % 256));
            if (AUTO)
                chk("load_ready", 32'(bus.load_ready),
                    32'(q.size() == 0 || (q.size() == 1 && bus.ser_ready)));
            else
                chk("load_ready", 32'(bus.load_ready), 32'(q.size() == 0));
            if (q.size() != 0) begin
                e = q[0];
                chk("ser_out", 32'(bus.ser_out), 32'(e.b));
                chk("ser_first", 32'(bus.ser_first), 32'(e.f));
                chk("ser_last", 32'(bus.ser_last), 32'(e.l));
                if (bus.ser_ready) begin
                    void'(q.pop_front());
                    if (e.l) model_wc++;
                end
            end else begin
                chk("idle_out", 32'({bus.ser_out, bus.ser_first, bus.ser_last}), 32'd0);
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer a word and drop load_valid right after it is taken.
    task automatic send(logic [W-1:0] d, bit hold = 1'b0);
        bit took = 1'b0;
        bus.load_valid = 1'b1;
        bus.data_in    = d;
        for (int i = 0; i < 200 && !took; i++) begin
            @(negedge clk);
            if (bus.load_ready) took = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!hold) bus.load_valid = 1'b0;
        if (!took) begin
            errors++; checks++;
            $display("FAIL send_timeout: word %0h never accepted", d);
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            errors++; checks++;
            $display("FAIL drain_timeout: %0d bits outstanding", q.size());
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.load_valid = 1'b0;
        bus.data_in    = '0;
        bus.ser_ready  = 1'b0;
        #2;
        chk("rst_valid", 32'(bus.ser_valid), 32'd0);
        chk("rst_ready", 32'(bus.load_ready), 32'd1);
        chk("rst_wc", 32'(bus.word_count), 32'd0);
        chk("rst_out", 32'({bus.ser_out, bus.ser_first, bus.ser_last}), 32'd0);
        tick(2);
        rst = 1'b0;
        tick();

        // 8'h96 with continuous ready
        bus.ser_ready = 1'b1;
        send(8'h96);
        drain();
        tick();

        // 8'hA5 with a 3-cycle stall on the third bit
        send(8'hA5);
        tick(2);
        bus.ser_ready = 1'b0;
        tick(3);
        bus.ser_ready = 1'b1;
        drain();
        tick();

        // 8'h0F with a stray 8'hFF offer mid-word
        send(8'h0F);
        tick(3);
        bus.load_valid = 1'b1;
        bus.data_in    = 8'hFF;
        tick();
        bus.load_valid = 1'b0;
        drain();
        tick();

        // Asynchronous reset after 3 bits of 8'hC3
        send(8'hC3);
        tick(3);
        #1;
        rst = 1'b1;
        #1;
        q.delete();
        model_wc = 0;
        chk("arst_valid", 32'(bus.ser_valid), 32'd0);
        chk("arst_wc", 32'(bus.word_count), 32'd0);
        chk("arst_ready", 32'(bus.load_ready), 32'd1);
        chk("arst_out", 32'({bus.ser_out, bus.ser_first, bus.ser_last}), 32'd0);
        bus.load_valid = 1'b1;
        bus.data_in    = 8'h55;
        tick(2);
        chk("rst_no_accept", 32'(bus.ser_valid), 32'd0);
        bus.load_valid = 1'b0;
        rst = 1'b0;
        tick();
        send(8'h03);
        drain();
        tick();

        // Two consecutive loads, load_valid held between them
        send(8'h81, 1'b1);
        send(8'h7E);
        drain();
        tick();

        // 256 back-to-back words: word_count wraps
        for (int i = 0; i < 256; i++) send(W'($urandom), 1'b1);
        bus.load_valid = 1'b0;
        drain();
        tick();
        chk("wrap_wc", 32'(bus.word_count), 32'(model_wc % 256));

        // Random data, random gaps, random downstream back-pressure
        rnd_run = 1'b1;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    send(W'($urandom));
                    tick($urandom_range(0, 3));
                end
                rnd_run = 1'b0;
            end
            begin
                while (rnd_run) begin
                    bus.ser_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                bus.ser_ready = 1'b1;
            end
        join
        drain();
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
